// File: rtl/serial_loader.sv
// serial_loader: turns the boot serial byte stream into TileLink-A PutFullData writes
// and holds the core in reset until a packet's checksum verifies.
module serial_loader #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         BYTE_TIMEOUT = 100000,
    parameter int         ACK_TIMEOUT  = 64
) (
    input  logic        clock,
    input  logic        reset_in_n,
    input  logic        serial_valid,
    input  logic [7:0]  serial_data,
    output logic        bus_tla_a_valid,
    output logic [2:0]  bus_tla_a_opcode,
    output logic [2:0]  bus_tla_a_size,
    output logic [3:0]  bus_tla_a_source,
    output logic [31:0] bus_tla_a_address,
    output logic [3:0]  bus_tla_a_mask,
    output logic [31:0] bus_tla_a_data,
    input  logic        bus_tld_d_valid,
    input  logic        bus_tld_d_error,
    output logic        core_hold,
    output logic        done,
    output logic [2:0]  err,
    output logic [15:0] words_written
);
    localparam int IW = $clog2(BYTE_TIMEOUT + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CSUM, WAIT} state_t;
    state_t         state;
    logic           pending;
    logic [1:0]     byte_idx;
    logic [7:0]     csum;
    logic [31:0]    cur_addr;
    logic [23:0]    word;
    logic [15:0]    words_left;
    logic [IW-1:0]  idle_cnt;
    logic [AW-1:0]  ack_cnt;
    logic           active;
    logic [15:0]    next_count;
    assign active           = state inside {ADDR, COUNT, DATA, CSUM};
    assign next_count       = {serial_data, words_left[15:8]};
    assign bus_tla_a_opcode = 3'd0;
    assign bus_tla_a_size   = 3'd2;
    assign bus_tla_a_source = 4'd0;
    assign bus_tla_a_mask   = 4'hF;
    always_ff @(posedge clock) begin
        if (!reset_in_n) begin
            state             <= IDLE;
            core_hold         <= 1'b1;
            done              <= 1'b0;
            err               <= '0;
            words_written     <= '0;
            pending           <= 1'b0;
            bus_tla_a_valid   <= 1'b0;
            bus_tla_a_address <= '0;
            bus_tla_a_data    <= '0;
            byte_idx          <= '0;
            csum              <= '0;
            cur_addr          <= '0;
            word              <= '0;
            words_left        <= '0;
            idle_cnt          <= '0;
            ack_cnt           <= '0;
        end else begin
            done            <= 1'b0;
            bus_tla_a_valid <= 1'b0;
            if (pending) begin
                ack_cnt <= ack_cnt + 1'b1;
                if (bus_tld_d_valid) begin
                    pending <= 1'b0;
                    if (bus_tld_d_error) err[2] <= 1'b1;
                    else words_written <= words_written + 1'b1;
                end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                    pending <= 1'b0;
                    err[2]  <= 1'b1;
                    state   <= IDLE;
                end
            end
            // Checksum already matched; release only once the last write is acked cleanly.
            if (state == WAIT && !pending) begin
                done      <= !err[2];
                core_hold <= err[2];
                state     <= IDLE;
            end
            if (active) idle_cnt <= serial_valid ? '0 : idle_cnt + 1'b1;
            if (serial_valid) begin
                case (state)
                    IDLE: if (serial_data == SYNC_BYTE) begin
                        state         <= ADDR;
                        core_hold     <= 1'b1;
                        csum          <= '0;
                        words_written <= '0;
                        err           <= '0;
                        byte_idx      <= '0;
                        pending       <= 1'b0;
                        idle_cnt      <= '0;
                    end
                    ADDR: begin
                        csum     <= csum ^ serial_data;
                        byte_idx <= byte_idx + 1'b1;
                        cur_addr <= byte_idx == 2'd3 ? {serial_data, cur_addr[31:10], 2'b00} : {serial_data, cur_addr[31:8]};
                        if (byte_idx == 2'd3) state <= COUNT;
                    end
                    COUNT: begin
                        csum       <= csum ^ serial_data;
                        words_left <= next_count;
                        byte_idx   <= byte_idx[0] ? 2'd0 : 2'd1;
                        if (byte_idx[0]) state <= next_count != '0 ? DATA : CSUM;
                    end
                    DATA: begin
                        csum     <= csum ^ serial_data;
                        byte_idx <= byte_idx + 1'b1;
                        word     <= {serial_data, word[23:8]};
                        if (byte_idx == 2'd3) begin
                            if (pending) begin
                                err[0] <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                bus_tla_a_valid   <= 1'b1;
                                bus_tla_a_address <= cur_addr;
                                bus_tla_a_data    <= {serial_data, word};
                                cur_addr          <= cur_addr + 32'd4;
                                pending           <= 1'b1;
                                ack_cnt           <= '0;
                                words_left        <= words_left - 1'b1;
                                if (words_left == 16'd1) state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (serial_data != csum) err[1] <= 1'b1;
                        state <= serial_data == csum ? WAIT : IDLE;
                    end
                    default: ;
                endcase
            end
            if (active && !serial_valid && idle_cnt == IW'(BYTE_TIMEOUT - 1)) begin
                err[0] <= 1'b1;
                state  <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: directed packets against serial_loader with a write scoreboard and bus responder.
module tb_serial_loader;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int BT = 200;
    localparam int AT = 64;
    typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
    logic        clock = 1'b0;
    logic        reset_in_n = 1'b0;
    logic        serial_valid = 1'b0;
    logic [7:0]  serial_data = 8'h00;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid = 1'b0;
    logic        d_error = 1'b0;
    logic        core_hold;
    logic        done;
    logic [2:0]  err;
    logic [15:0] words_written;
    int total = 0, bad = 0;
    int cyc = 0, av_cyc = 0, nwrites = 0, done_cnt = 0, ack_cd = 0, ack_mode = 0;
    int d0, w0;
    wr_t exp_q[$];
    logic [7:0]  cs;
    logic [31:0] a_exp;

    serial_loader #(.SYNC_BYTE(SYNC), .BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT)) dut (
        .clock(clock), .reset_in_n(reset_in_n),
        .serial_valid(serial_valid), .serial_data(serial_data),
        .bus_tla_a_valid(a_valid), .bus_tla_a_opcode(a_opcode), .bus_tla_a_size(a_size),
        .bus_tla_a_source(a_source), .bus_tla_a_address(a_address), .bus_tla_a_mask(a_mask),
        .bus_tla_a_data(a_data), .bus_tld_d_valid(d_valid), .bus_tld_d_error(d_error),
        .core_hold(core_hold), .done(done), .err(err), .words_written(words_written)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pops on every write; responder acks two cycles later unless withheld.
    always @(negedge clock) begin
        wr_t e;
        if (!reset_in_n) ack_cd = 0;
        if (done) done_cnt++;
        if (a_valid) begin
            nwrites++;
            av_cyc = cyc;
            check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", a_address, e.addr);
                check("wr_data", a_data, e.data);
                check("wr_mask", a_mask, 4'hF);
                check("wr_opcode", a_opcode, 3'd0);
                check("wr_size", a_size, 3'd2);
                check("wr_source", a_source, 4'd0);
            end
            if (ack_mode != 2) ack_cd = 2;
        end
        d_valid = 1'b0;
        d_error = 1'b0;
        if (ack_cd > 0) begin
            ack_cd--;
            if (ack_cd == 0) begin
                d_valid = 1'b1;
                d_error = ack_mode == 1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        serial_valid = 1'b1;
        serial_data  = b;
        @(posedge clock); #1;
        serial_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] addr, input logic [15:0] n);
        send_byte(SYNC);
        cs    = 8'h00;
        a_exp = {addr[31:2], 2'b00};
        for (int i = 0; i < 4; i++) begin
            cs ^= addr[8*i +: 8];
            send_byte(addr[8*i +: 8]);
        end
        for (int i = 0; i < 2; i++) begin
            cs ^= n[8*i +: 8];
            send_byte(n[8*i +: 8]);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back({a_exp, w});
        a_exp += 32'd4;
        for (int i = 0; i < 4; i++) begin
            cs ^= w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic settle();
        repeat (20) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_core_hold", core_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_written, 0);
        check("rst_a_valid", a_valid, 0);
        @(posedge clock); #1 reset_in_n = 1'b1;

        send_byte(8'h00);
        send_byte(8'h5A);
        settle();
        check("garbage_writes", nwrites, 0);
        check("garbage_err", err, 0);

        d0 = done_cnt;
        send_hdr(32'h8000_0000, 16'd1);
        send_word(32'hDEAD_BEEF);
        send_byte(cs);
        settle();
        check("good_done_pulses", done_cnt - d0, 1);
        check("good_core_hold", core_hold, 0);
        check("good_words", words_written, 1);
        check("good_err", err, 0);
        check("good_writes", nwrites, 1);

        d0 = done_cnt;
        send_hdr(32'hFFFF_FFFC, 16'd2);
        check("rehold_core", core_hold, 1);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        send_byte(cs);
        settle();
        check("wrap_done_pulses", done_cnt - d0, 1);
        check("wrap_words", words_written, 2);
        check("wrap_core_hold", core_hold, 0);
        check("wrap_err", err, 0);

        d0 = done_cnt;
        send_hdr(32'h8000_0000, 16'd1);
        send_word(32'hDEAD_BEEF);
        send_byte(cs ^ 8'h01);
        settle();
        check("badcs_err", err, 3'b010);
        check("badcs_done", done_cnt - d0, 0);
        check("badcs_core_hold", core_hold, 1);
        check("badcs_writes", nwrites, 4);

        ack_mode = 1;
        d0 = done_cnt;
        send_hdr(32'h0000_0040, 16'd1);
        send_word(32'h0BAD_0BAD);
        send_byte(cs);
        settle();
        check("buserr_err", err, 3'b100);
        check("buserr_words", words_written, 0);
        check("buserr_done", done_cnt - d0, 0);
        check("buserr_core_hold", core_hold, 1);

        ack_mode = 2;
        d0 = done_cnt;
        send_hdr(32'h0000_2000, 16'd1);
        send_word(32'h1234_5678);
        send_byte(cs);
        while (cyc < av_cyc + AT - 4) @(negedge clock);
        check("acktmo_early_err", err, 3'b000);
        while (cyc < av_cyc + AT + 2) @(negedge clock);
        check("acktmo_err", err, 3'b100);
        check("acktmo_done", done_cnt - d0, 0);
        check("acktmo_core_hold", core_hold, 1);
        ack_mode = 0;

        send_byte(SYNC);
        send_byte(8'h10);
        send_byte(8'h20);
        repeat (BT - 15) @(negedge clock);
        check("bytetmo_early_err", err, 3'b000);
        repeat (20) @(negedge clock);
        check("bytetmo_err", err, 3'b001);
        check("bytetmo_core_hold", core_hold, 1);

        send_hdr(32'h0000_1000, 16'd2);
        send_word(32'hCAFE_F00D);
        repeat (4) @(negedge clock);
        check("prerst_words", words_written, 1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        @(posedge clock); #1 reset_in_n = 1'b0;
        @(posedge clock); #1 reset_in_n = 1'b1;
        @(negedge clock);
        check("midrst_core_hold", core_hold, 1);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_words", words_written, 0);
        check("midrst_a_valid", a_valid, 0);
        w0 = nwrites;
        send_byte(8'h04);
        send_byte(8'h55);
        settle();
        check("midrst_no_write", nwrites - w0, 0);

        d0 = done_cnt;
        send_hdr(32'h0000_3000, 16'd1);
        send_word(32'hA5A5_0001);
        send_byte(cs);
        settle();
        check("reload_done_pulses", done_cnt - d0, 1);
        check("reload_words", words_written, 1);
        check("reload_core_hold", core_hold, 0);
        check("reload_err", err, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_loader.md
Name: serial_loader

Overview:
- Boot-time front end that turns the top-level serial byte stream (serial_valid/serial_data) into TileLink-A PutFullData writes into code/data RAM.
- Sits upstream of the bus RAMs; it is muxed onto the core's bus_tla slot while core_hold=1.
- Holds the core in reset until a packet's checksum verifies.
- Then releases the core with a one-cycle done pulse.

Parameters:
- SYNC_BYTE, 8'hA5, packet start marker.
- BYTE_TIMEOUT, 100000, max cycles between bytes inside a packet before abort.
- ACK_TIMEOUT, 64, max cycles from a_valid to d_valid before bus error.

Ports:
- clock  in  1  global clock, all state on rising edge.
- reset_in_n  in  1  synchronous, active-low reset.
- serial_valid  in  1  one-cycle strobe, serial_data is valid.
- serial_data  in  8  received byte.
- bus_tla  out  tilelink_a  write request to RAM bus.
- bus_tld  in  tilelink_d  response from RAM bus.
- core_hold  out  1  holds core reset; loader owns bus.
- done  out  1  one-cycle pulse on verified packet.
- err  out  3  sticky {bus_err, csum_err, overrun/timeout}.
- words_written  out  16  acked word count of current packet.

Behaviour:
- Reset (reset_in_n=0 at edge):
  - state=IDLE, core_hold=1, done=0, err=0, words_written=0, pending=0, bus_tla.a_valid=0.
  - Reset mid-packet discards everything; no write is issued after reset.
- Packet format, after SYNC_BYTE:
  - addr[31:0] as 4 bytes, little-endian.
  - count[15:0] as 2 bytes, little-endian.
  - count×4 data bytes, each word little-endian.
  - 1 checksum byte: XOR of every byte after the sync byte.
- States: IDLE -> ADDR -> COUNT -> DATA -> CSUM -> IDLE.
  - IDLE: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE: clear csum/words_written, byte_idx=0, go to ADDR.
  - ADDR: after 4 bytes, addr[1:0] forced to 0. Go to COUNT.
  - COUNT: after 2 bytes, go to DATA if count≠0, else go to CSUM.
  - DATA: 4th byte of a word issues a write (below). After count words, go to CSUM.
  - CSUM: on the byte, if it equals running XOR, pulse done and set core_hold=0. Otherwise set err[1]. Either way return to IDLE.
- core_hold is set back to 1 on entering ADDR. A new packet re-holds the core.
- Write issue:
  - The cycle after the 4th data byte, drive bus_tla for exactly one cycle: a_valid=1, a_opcode=PutFullData(0), a_size=2, a_mask=4'hF, a_source=0, a_address=cur_addr, a_data=assembled word. Set pending=1.
  - All other cycles: a_valid=0, other fields don't-care.
  - cur_addr increments by 4 after each issue, 32-bit wrap (FFFFFFFC -> 00000000).
- Ack:
  - First bus_tld.d_valid=1 while pending: pending=0, words_written+1.
  - If d_error=1, set err[2] instead of incrementing.
  - If pending lasts ACK_TIMEOUT cycles: set err[2], pending=0, abort to IDLE.
  - d_valid while not pending is ignored.
- Overrun: a 4th data byte arriving while pending=1 sets err[0], aborts to IDLE, and issues no write.
- Checksum byte with pending=1 is legal. done fires only after pending clears, and no later than ACK_TIMEOUT cycles.
- Byte timeout: in ADDR/COUNT/DATA/CSUM, an idle counter resets on each serial_valid. At BYTE_TIMEOUT it sets err[0] and returns to IDLE. The counter is inactive in IDLE.
- Abort of any kind leaves core_hold=1.
- err bits are sticky until reset or the next SYNC_BYTE accepted in IDLE.
- serial_valid is sampled every cycle. Back-to-back bytes on consecutive cycles are legal.
- The internal one-word buffer is enough because a word needs 4 strobes.

Test Plan:
- Good 1-word packet:
  - Send A5, 00 00 00 80, 01 00, EF BE AD DE, csum=0x80^0x01^0xEF^0xBE^0xAD^0xDE.
  - Required: one a_valid, address 0x80000000, data 0xDEADBEEF, mask F.
  - After the d_valid ack: done=1 for 1 cycle, core_hold=0, words_written=1, err=0.
- Multi-word with wrap:
  - addr FC FF FF FF, count 02.
  - Required: writes to 0xFFFFFFFC then 0x00000000, words_written=2, done pulse.
- Bad checksum:
  - Good 1-word packet with csum^0x01.
  - Required: write still issued, err=3'b010, no done, core_hold stays 1.
- Bus error:
  - Respond with d_error=1.
  - Required: err[2]=1, words_written=0. On csum, no done.
- Timeouts:
  - Withhold d_valid for ACK_TIMEOUT cycles: err[2]=1, state IDLE.
  - Stop bytes mid-ADDR for BYTE_TIMEOUT cycles: err[0]=1, state IDLE.
- Reset/garbage:
  - Bytes 00 5A before sync: ignored.
  - Deassert reset_in_n for one cycle mid-DATA: a_valid stays 0, all outputs return to reset values.
  - Next valid packet: loads normally.
